// File: rtl/vdp_video_pkg.sv
// Shared video types for the VDP scan-doubler path: colour/pixel widths,
// default timing constants and the scanline dimming helper.
package vdp_video_pkg;

  localparam int COLOR_W        = 6;
  localparam int PIX_W          = 3 * COLOR_W;
  localparam int DEF_LEN_NTSC   = 342;
  localparam int HS_OUT_LEN_DEF = 20;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } pixel_t;

  // Halve each channel independently so no bit leaks between channels.
  function automatic pixel_t dim_pixel(input pixel_t p);
    pixel_t d;
    d.r = p.r >> 1;
    d.g = p.g >> 1;
    d.b = p.b >> 1;
    return d;
  endfunction

endpackage

// File: rtl/vdp_line_buffer.sv
// Ping-pong line store: one write port, one registered read port, no reset
// so it maps onto a plain block RAM.
module vdp_line_buffer
  import vdp_video_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW:0] wr_addr,
  input  pixel_t      wr_data,
  input  logic [AW:0] rd_addr,
  output pixel_t      rd_data
);

  pixel_t mem [0:(2**(AW+1))-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vdp_scandoubler.sv
// Line doubler: stores each 15 kHz input line in one bank and replays the
// previous line twice at 2x pixel rate, optionally dimming the repeat.
module vdp_scandoubler
  import vdp_video_pkg::*;
#(
  parameter int AW         = 9,
  parameter int DEF_LEN    = DEF_LEN_NTSC,
  parameter int HS_OUT_LEN = HS_OUT_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ena_in,
  input  logic               ena_out,
  input  logic               scanlines,
  input  logic               HS_in,
  input  logic               VS_in,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  output logic               HS_out,
  output logic               VS_out,
  output logic [COLOR_W-1:0] R_out,
  output logic [COLOR_W-1:0] G_out,
  output logic [COLOR_W-1:0] B_out
);

  localparam logic [AW-1:0] X_MAX     = '1;
  localparam logic [AW:0]   MAX_LEN   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   DEF_LEN_W = DEF_LEN[AW:0];
  localparam logic [AW-1:0] HS_LEN_W  = HS_OUT_LEN[AW-1:0];

  logic          hs_d;
  logic          hs_fall;
  logic [AW-1:0] in_x;
  logic [AW:0]   in_len;
  logic [AW:0]   new_len;
  logic          wr_bank;
  logic          vs_lat;
  logic          we;
  logic [AW:0]   wr_addr;

  logic [AW-1:0] out_x;
  logic [AW-1:0] out_x_d;
  logic [AW:0]   out_len;
  logic          rd_bank;
  logic          odd;
  logic          odd_d;
  pixel_t        rd_data;
  pixel_t        shown;

  assign hs_fall = ena_in & hs_d & ~HS_in;
  assign new_len = (in_x == X_MAX) ? MAX_LEN : ({1'b0, in_x} + 1'b1);

  // in_x holds the address of the last pixel written, so the line-start
  // pixel lands at 0 and in_x+1 is the pixel count at the next line start.
  assign we      = ena_in & (hs_fall | (in_x != X_MAX));
  assign wr_addr = hs_fall ? {~wr_bank, {AW{1'b0}}} : {wr_bank, in_x + 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d    <= 1'b1;
      in_x    <= '0;
      in_len  <= '0;
      wr_bank <= 1'b0;
      vs_lat  <= 1'b1;
    end else if (ena_in) begin
      hs_d <= HS_in;
      if (hs_fall) begin
        in_len  <= new_len;
        in_x    <= '0;
        wr_bank <= ~wr_bank;
        vs_lat  <= VS_in;
      end else if (in_x != X_MAX) begin
        in_x <= in_x + 1'b1;
      end
    end
  end

  // in_len only moves on hs_fall, which also restarts the output line, so
  // the replay length can never change part way through a line.
  assign out_len = (in_len == '0) ? DEF_LEN_W : in_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_x   <= '0;
      odd     <= 1'b0;
      rd_bank <= 1'b1;
      VS_out  <= 1'b1;
    end else if (hs_fall) begin
      out_x   <= '0;
      odd     <= 1'b0;
      rd_bank <= wr_bank;
      VS_out  <= vs_lat;
    end else if (ena_out) begin
      if ({1'b0, out_x} == (out_len - 1'b1)) begin
        out_x <= '0;
        odd   <= 1'b1;
      end else begin
        out_x <= out_x + 1'b1;
      end
    end
  end

  vdp_line_buffer #(.AW(AW)) u_line_buffer (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data ({R_in, G_in, B_in}),
    .rd_addr ({rd_bank, out_x}),
    .rd_data (rd_data)
  );

  // Delay position and line parity one clk so they line up with RAM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_x_d <= '0;
      odd_d   <= 1'b0;
    end else begin
      out_x_d <= out_x;
      odd_d   <= odd;
    end
  end

  assign shown = (scanlines & odd_d) ? dim_pixel(rd_data) : rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HS_out <= 1'b1;
      R_out  <= '0;
      G_out  <= '0;
      B_out  <= '0;
    end else if (ena_out) begin
      HS_out <= ~(out_x_d < HS_LEN_W);
      R_out  <= shown.r;
      G_out  <= shown.g;
      B_out  <= shown.b;
    end
  end

endmodule

// File: tb/tb_vdp_scandoubler.sv
// Directed bench for vdp_scandoubler: a VDP-like line source feeds the DUT
// and each replayed line pair is compared tick by tick against expectations.
module tb_vdp_scandoubler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena_in;
  logic       ena_out;
  logic       scanlines;
  logic       HS_in;
  logic       VS_in;
  logic [5:0] R_in, G_in, B_in;
  logic       HS_out;
  logic       VS_out;
  logic [5:0] R_out, G_out, B_out;

  int checks = 0;
  int errors = 0;

  int cyc         = 0;
  int px          = 341;
  int cur_len     = 342;
  int len_req     = 342;
  int line_starts = 0;
  int seen        = 0;
  int vs_req      = 0;
  int vs_done     = 0;
  bit cur_const   = 1'b0;
  bit const_req   = 1'b0;

  always #5 clk = ~clk;

  vdp_scandoubler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena_in    (ena_in),
    .ena_out   (ena_out),
    .scanlines (scanlines),
    .HS_in     (HS_in),
    .VS_in     (VS_in),
    .R_in      (R_in),
    .G_in      (G_in),
    .B_in      (B_in),
    .HS_out    (HS_out),
    .VS_out    (VS_out),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out)
  );

  // Strobes and line source: ena_out every 2 clk, ena_in every 4 clk,
  // HS_in low for the first 26 pixels, length/mode/VS picked at line start.
  initial begin
    logic [5:0] pix;
    ena_in = 1'b0;
    ena_out = 1'b0;
    HS_in = 1'b1;
    VS_in = 1'b1;
    R_in = '0;
    G_in = '0;
    B_in = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ena_out = (cyc % 2 == 0);
      ena_in  = (cyc % 4 == 0);
      if (ena_in) begin
        if (px >= cur_len - 1) begin
          px = 0;
          cur_len = len_req;
          cur_const = const_req;
          line_starts++;
          if (vs_done < vs_req) begin
            VS_in = 1'b0;
            vs_done++;
          end else begin
            VS_in = 1'b1;
          end
        end else begin
          px++;
        end
        pix   = px[5:0];
        HS_in = (px < 26) ? 1'b0 : 1'b1;
        R_in  = cur_const ? 6'h3F : pix;
        G_in  = cur_const ? 6'h3F : 6'h3F - pix;
        B_in  = cur_const ? 6'h3F : 6'h2A;
      end
    end
  end

  task automatic check(input string tag, input int k, input logic [5:0] obs,
                       input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic wait_out_tick();
    int guard = 0;
    @(posedge clk);
    while (!ena_out && guard < 8) begin
      @(posedge clk);
      guard++;
    end
    #1;
  endtask

  task automatic sync_pair();
    int guard = 0;
    while (line_starts == seen && guard < 6000) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    assert (line_starts != seen) else begin
      errors++;
      $error("FAIL sync: observed no input line start, expected one within 6000 clk");
    end
    seen = line_starts;
  endtask

  // Compare n output ticks of the pair replaying a line of length len.
  task automatic check_ticks(input int len, input int n, input bit cm, input bit vs_exp);
    int         x;
    logic [5:0] pix, r, g, b;
    for (int k = 0; k < n; k++) begin
      wait_out_tick();
      x   = k % len;
      pix = x[5:0];
      r   = cm ? 6'h3F : pix;
      g   = cm ? 6'h3F : 6'h3F - pix;
      b   = cm ? 6'h3F : 6'h2A;
      if (scanlines && k >= len) begin
        r = r >> 1;
        g = g >> 1;
        b = b >> 1;
      end
      check("HS_out", k, {5'b0, HS_out}, (x < 20) ? 6'd0 : 6'd1);
      check("VS_out", k, {5'b0, VS_out}, {5'b0, vs_exp});
      check("R_out", k, R_out, r);
      check("G_out", k, G_out, g);
      check("B_out", k, B_out, b);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    scanlines = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_HS", 0, {5'b0, HS_out}, 6'd1);
    check("rst_VS", 0, {5'b0, VS_out}, 6'd1);
    check("rst_R", 0, R_out, 6'd0);
    check("rst_G", 0, G_out, 6'd0);
    check("rst_B", 0, B_out, 6'd0);

    repeat (700) @(posedge clk);
    #3 reset_n = 1'b1;
    seen = line_starts;

    $display("[TB] ramp lines, scanlines off");
    sync_pair();
    sync_pair();
    check_ticks(342, 683, 1'b0, 1'b1);

    $display("[TB] ramp lines, scanlines on");
    scanlines = 1'b1;
    sync_pair();
    check_ticks(342, 683, 1'b0, 1'b1);

    $display("[TB] flat 3F lines");
    const_req = 1'b1;
    sync_pair();
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b1);
    scanlines = 1'b0;
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b1);

    $display("[TB] vsync over three input lines");
    vs_req += 3;
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b1);
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b0);
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b0);
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b0);
    sync_pair();
    check_ticks(342, 683, 1'b1, 1'b1);

    $display("[TB] long line then short line");
    const_req = 1'b0;
    len_req   = 600;
    sync_pair();
    len_req = 300;
    check_ticks(342, 683, 1'b1, 1'b1);
    sync_pair();
    len_req = 342;
    check_ticks(512, 599, 1'b0, 1'b1);
    sync_pair();
    check_ticks(300, 683, 1'b0, 1'b1);

    $display("[TB] asynchronous reset during vsync");
    const_req = 1'b1;
    vs_req += 3;
    sync_pair();
    sync_pair();
    repeat (6) wait_out_tick();
    check("pre_HS", 5, {5'b0, HS_out}, 6'd0);
    check("pre_VS", 5, {5'b0, VS_out}, 6'd0);
    check("pre_R", 5, R_out, 6'h3F);
    #2 reset_n = 1'b0;
    #1;
    check("async_HS", 5, {5'b0, HS_out}, 6'd1);
    check("async_VS", 5, {5'b0, VS_out}, 6'd1);
    check("async_R", 5, R_out, 6'd0);
    check("async_G", 5, G_out, 6'd0);
    check("async_B", 5, B_out, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
